// File: rtl/reg_dump.sv
// Debug scan-out engine: walks a register range through the sampling read port and streams
// header, {addr, data_hi, data_lo} per register and an optional checksum (REG_DUMP_CSUM_EN).
module reg_dump #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 4,
   parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_first_addr,
   input  logic [ADDR_W-1:0] i_last_addr,
   output logic              o_rse,
   output logic [ADDR_W-1:0] o_rsaddr,
   input  logic [DATA_W-1:0] i_rsdata,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_valid,
   input  logic              i_tx_ready,
   output logic              o_busy,
   output logic              o_done
);

`ifdef REG_DUMP_CSUM_EN
   typedef enum logic [2:0] {
      StIdle, StHdr, StSample, StAddr, StDhi, StDlo, StCsum, StDone
   } state_e;
`else
   typedef enum logic [2:0] {
      StIdle, StHdr, StSample, StAddr, StDhi, StDlo, StDone
   } state_e;
`endif

   state_e            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
   // Registers left after the current one, so the range wraps naturally mod 2^ADDR_W.
   logic [ADDR_W-1:0] r_remain, w_remain_nxt;
   logic [DATA_W-1:0] r_hold, w_hold_nxt;
   logic [7:0]        w_addr_byte;
`ifdef REG_DUMP_CSUM_EN
   logic [7:0]        r_csum, w_csum_nxt;
`endif

   assign w_addr_byte = 8'(r_ptr);
   assign o_rsaddr    = r_ptr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= StIdle;
         r_ptr    <= '0;
         r_remain <= '0;
         r_hold   <= '0;
`ifdef REG_DUMP_CSUM_EN
         r_csum   <= '0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_ptr    <= w_ptr_nxt;
         r_remain <= w_remain_nxt;
         r_hold   <= w_hold_nxt;
`ifdef REG_DUMP_CSUM_EN
         r_csum   <= w_csum_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_remain_nxt = r_remain;
      w_hold_nxt   = r_hold;
`ifdef REG_DUMP_CSUM_EN
      w_csum_nxt   = r_csum;
`endif
      o_rse        = 1'b0;
      o_tx_valid   = 1'b0;
      o_tx_data    = 8'h00;
      o_busy       = 1'b1;
      o_done       = 1'b0;

      unique case (r_state)
         StIdle: begin
            o_busy = 1'b0;
            if (i_start) begin
               w_ptr_nxt    = i_first_addr;
               w_remain_nxt = i_last_addr - i_first_addr;
`ifdef REG_DUMP_CSUM_EN
               w_csum_nxt   = 8'h00;
`endif
               w_state_nxt  = StHdr;
            end
         end
         StHdr: begin
            o_tx_valid = 1'b1;
            o_tx_data  = HDR_BYTE;
            if (i_tx_ready) w_state_nxt = StSample;
         end
         StSample: begin
            // rsdata already includes the register file's write bypass.
            o_rse       = 1'b1;
            w_hold_nxt  = i_rsdata;
            w_state_nxt = StAddr;
         end
         StAddr: begin
            o_tx_valid = 1'b1;
            o_tx_data  = w_addr_byte;
            if (i_tx_ready) begin
`ifdef REG_DUMP_CSUM_EN
               w_csum_nxt = r_csum + w_addr_byte;
`endif
               w_state_nxt = StDhi;
            end
         end
         StDhi: begin
            o_tx_valid = 1'b1;
            o_tx_data  = r_hold[15:8];
            if (i_tx_ready) begin
`ifdef REG_DUMP_CSUM_EN
               w_csum_nxt = r_csum + r_hold[15:8];
`endif
               w_state_nxt = StDlo;
            end
         end
         StDlo: begin
            o_tx_valid = 1'b1;
            o_tx_data  = r_hold[7:0];
            if (i_tx_ready) begin
`ifdef REG_DUMP_CSUM_EN
               w_csum_nxt = r_csum + r_hold[7:0];
`endif
               if (r_remain != '0) begin
                  w_remain_nxt = r_remain - ADDR_W'(1);
                  w_ptr_nxt    = r_ptr + ADDR_W'(1);
                  w_state_nxt  = StSample;
               end else begin
`ifdef REG_DUMP_CSUM_EN
                  w_state_nxt = StCsum;
`else
                  w_state_nxt = StDone;
`endif
               end
            end
         end
`ifdef REG_DUMP_CSUM_EN
         StCsum: begin
            o_tx_valid = 1'b1;
            o_tx_data  = r_csum;
            if (i_tx_ready) w_state_nxt = StDone;
         end
`endif
         StDone: begin
            o_busy      = 1'b0;
            o_done      = 1'b1;
            w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

endmodule
